// File: rtl/eth_types_pkg.sv
// rtl/eth_types_pkg.sv - Ethernet/IPv4/UDP receive constants, header offsets and parser state type
package eth_types_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;

    // Byte offsets of the checked fields, relative to the start of each header.
    localparam int ETH_DMAC_LEN  = 6;
    localparam int ETH_TYPE_OFS  = 12;
    localparam int IP_PROTO_OFS  = 9;
    localparam int IP_DST_OFS    = 16;
    localparam int UDP_DPORT_OFS = 2;
    localparam int UDP_LEN_OFS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ETH_HDR,
        ST_IP_HDR,
        ST_UDP_HDR,
        ST_PAYLOAD,
        ST_DRAIN
    } rx_state_t;

    // Byte idx of a MAC address in wire order (idx 0 is the first byte sent).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        return mac[8*(5-int'(idx)) +: 8];
    endfunction

    // Byte idx of an IPv4 address in wire order.
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        return ip[8*(3-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Ports:
//   clk     in  clock
//   resetn  in  asynchronous active-low reset, clears count
//   inc     in  add one this cycle (ignored once count is all-ones)
//   count   out current count, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/udp_rx_demux.sv
// rtl/udp_rx_demux.sv - Ethernet/IPv4/UDP receive parser demultiplexing payload over consecutive UDP ports
//
// Ports:
//   clk            in  RMII reference clock
//   resetn         in  asynchronous active-low reset
//   data_valid     in  frame active (CRS_DV)
//   received_byte  in  assembled byte from the RMII front end
//   byte_valid     in  one-cycle strobe qualifying received_byte
//   payload        out payload byte
//   payload_valid  out payload byte strobe
//   payload_last   out marks the final payload byte of a frame
//   payload_chan   out dest_port - BASE_PORT, stable across the frame
//   frame_drop     out one-cycle pulse when an accepted frame ends inside its payload
//   ok_count       out frames fully delivered (saturating)
//   drop_count     out frames rejected or truncated after SFD (saturating)
module udp_rx_demux
    import eth_types_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC     = 48'h00_1A_2B_3C_4D_5E,
    parameter logic [31:0] FPGA_IP      = 32'hC0_00_02_92,
    parameter logic [15:0] BASE_PORT    = 16'd5005,
    parameter int          NUM_PORTS    = 4,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int          CNT_W        = 16,
    localparam int         CHAN_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_valid,
    input  logic [7:0]        received_byte,
    input  logic              byte_valid,
    output logic [7:0]        payload,
    output logic              payload_valid,
    output logic              payload_last,
    output logic [CHAN_W-1:0] payload_chan,
    output logic              frame_drop,
    output logic [CNT_W-1:0]  ok_count,
    output logic [CNT_W-1:0]  drop_count
);

    rx_state_t   state, state_n;
    logic [4:0]  offset, offset_n;
    logic        uni_ok, uni_ok_n;
    logic        bc_ok, bc_ok_n;
    logic [7:0]  port_hi, port_hi_n;
    logic [7:0]  len_hi, len_hi_n;
    logic [15:0] remain, remain_n;

    logic [7:0]        pay_n;
    logic              pay_v_n;
    logic              pay_last_n;
    logic [CHAN_W-1:0] chan_n;
    logic              drop_pulse_n;
    logic              ok_inc;
    logic              drop_inc;
    logic              hdr_fail;
    logic [16:0]       port_ext;
    logic [15:0]       udp_len;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            offset        <= '0;
            uni_ok        <= 1'b0;
            bc_ok         <= 1'b0;
            port_hi       <= '0;
            len_hi        <= '0;
            remain        <= '0;
            payload       <= '0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            payload_chan  <= '0;
            frame_drop    <= 1'b0;
        end else begin
            state         <= state_n;
            offset        <= offset_n;
            uni_ok        <= uni_ok_n;
            bc_ok         <= bc_ok_n;
            port_hi       <= port_hi_n;
            len_hi        <= len_hi_n;
            remain        <= remain_n;
            payload       <= pay_n;
            payload_valid <= pay_v_n;
            payload_last  <= pay_last_n;
            payload_chan  <= chan_n;
            frame_drop    <= drop_pulse_n;
        end
    end

    always_comb begin
        state_n      = state;
        offset_n     = offset;
        uni_ok_n     = uni_ok;
        bc_ok_n      = bc_ok;
        port_hi_n    = port_hi;
        len_hi_n     = len_hi;
        remain_n     = remain;
        pay_n        = payload;
        pay_v_n      = 1'b0;
        pay_last_n   = 1'b0;
        chan_n       = payload_chan;
        drop_pulse_n = 1'b0;
        ok_inc       = 1'b0;
        drop_inc     = 1'b0;
        hdr_fail     = 1'b0;
        port_ext     = {1'b0, port_hi, received_byte};
        udp_len      = {len_hi, received_byte};

        // The byte arriving this cycle is consumed first; end-of-frame is
        // judged afterwards on the resulting state.
        case (state)
            ST_IDLE: begin
                if (data_valid) begin
                    state_n = ST_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                if (byte_valid) begin
                    if (received_byte == SFD_BYTE) begin
                        state_n  = ST_ETH_HDR;
                        offset_n = '0;
                        uni_ok_n = 1'b1;
                        bc_ok_n  = ACCEPT_BCAST;
                    end else if (received_byte != PREAMBLE_BYTE) begin
                        // Garbage before SFD: not a frame, so nothing is counted.
                        state_n = ST_DRAIN;
                    end
                end
            end

            ST_ETH_HDR: begin
                if (byte_valid) begin
                    offset_n = offset + 5'd1;
                    if (offset < 5'(ETH_DMAC_LEN)) begin
                        // Unicast and broadcast candidates are tracked separately;
                        // the frame is rejected as soon as neither can still match.
                        uni_ok_n = uni_ok && (received_byte == mac_byte(FPGA_MAC, offset[2:0]));
                        bc_ok_n  = bc_ok && (received_byte == mac_byte(BCAST_MAC, offset[2:0]));
                        hdr_fail = !uni_ok_n && !bc_ok_n;
                    end else if (offset == 5'(ETH_TYPE_OFS)) begin
                        hdr_fail = (received_byte != ETHERTYPE_IPV4[15:8]);
                    end else if (offset == 5'(ETH_HDR_LEN - 1)) begin
                        hdr_fail = (received_byte != ETHERTYPE_IPV4[7:0]);
                        state_n  = ST_IP_HDR;
                        offset_n = '0;
                    end
                end
            end

            ST_IP_HDR: begin
                if (byte_valid) begin
                    offset_n = offset + 5'd1;
                    if (offset == 5'd0) begin
                        hdr_fail = (received_byte != IPV4_VER_IHL);
                    end else if (offset == 5'(IP_PROTO_OFS)) begin
                        hdr_fail = (received_byte != IP_PROTO_UDP);
                    end else if (offset >= 5'(IP_DST_OFS)) begin
                        // Offsets 16..19 map to address bytes 0..3 via their low bits.
                        hdr_fail = (received_byte != ip_byte(FPGA_IP, offset[1:0]));
                    end
                    if (offset == 5'(IP_HDR_LEN - 1)) begin
                        state_n  = ST_UDP_HDR;
                        offset_n = '0;
                    end
                end
            end

            ST_UDP_HDR: begin
                if (byte_valid) begin
                    offset_n = offset + 5'd1;
                    if (offset == 5'(UDP_DPORT_OFS)) begin
                        port_hi_n = received_byte;
                    end else if (offset == 5'(UDP_DPORT_OFS + 1)) begin
                        // 17-bit compare so a range ending past 0xFFFF cannot wrap.
                        if ((port_ext >= {1'b0, BASE_PORT}) &&
                            (port_ext < ({1'b0, BASE_PORT} + 17'(NUM_PORTS)))) begin
                            chan_n = CHAN_W'(port_ext[15:0] - BASE_PORT);
                        end else begin
                            hdr_fail = 1'b1;
                        end
                    end else if (offset == 5'(UDP_LEN_OFS)) begin
                        len_hi_n = received_byte;
                    end else if (offset == 5'(UDP_LEN_OFS + 1)) begin
                        if (udp_len < 16'(UDP_HDR_LEN)) begin
                            hdr_fail = 1'b1;
                        end else begin
                            remain_n = udp_len - 16'(UDP_HDR_LEN);
                        end
                    end else if (offset == 5'(UDP_HDR_LEN - 1)) begin
                        if (remain == '0) begin
                            ok_inc  = 1'b1;
                            state_n = ST_DRAIN;
                        end else begin
                            state_n = ST_PAYLOAD;
                        end
                    end
                end
            end

            ST_PAYLOAD: begin
                if (byte_valid) begin
                    pay_n    = received_byte;
                    pay_v_n  = 1'b1;
                    remain_n = remain - 16'd1;
                    if (remain == 16'd1) begin
                        // Anything after the UDP length (padding, FCS) is drained unseen.
                        pay_last_n = 1'b1;
                        ok_inc     = 1'b1;
                        state_n    = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (hdr_fail) begin
            state_n  = ST_DRAIN;
            drop_inc = 1'b1;
        end

        if (!data_valid) begin
            if ((state_n == ST_ETH_HDR) || (state_n == ST_IP_HDR) || (state_n == ST_UDP_HDR)) begin
                drop_inc = 1'b1;
            end else if (state_n == ST_PAYLOAD) begin
                drop_inc     = 1'b1;
                drop_pulse_n = 1'b1;
            end
            state_n = ST_IDLE;
        end
    end

    sat_counter #(.W(CNT_W)) u_ok_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ok_inc),
        .count  (ok_count)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (drop_inc),
        .count  (drop_count)
    );

endmodule

// File: tb/tb_udp_rx_demux.sv
// tb/tb_udp_rx_demux.sv - self-checking bench for udp_rx_demux
module tb_udp_rx_demux;

    localparam logic [47:0] MAC  = 48'h00_1A_2B_3C_4D_5E;
    localparam logic [31:0] IP   = 32'hC0_00_02_92;
    localparam int          BASE = 5005;
    localparam int          NUM  = 4;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       data_valid = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] received_byte = 8'h00;

    logic [7:0]  payload, payload_nb, payload_sat;
    logic        payload_valid, payload_valid_nb, payload_valid_sat;
    logic        payload_last, payload_last_nb, payload_last_sat;
    logic [1:0]  payload_chan, payload_chan_nb, payload_chan_sat;
    logic        frame_drop, frame_drop_nb, frame_drop_sat;
    logic [15:0] ok_count, drop_count, ok_count_nb, drop_count_nb;
    logic [1:0]  ok_count_sat, drop_count_sat;

    always #10 clk = ~clk;

    udp_rx_demux u_dut (
        .clk(clk), .resetn(resetn), .data_valid(data_valid), .received_byte(received_byte),
        .byte_valid(byte_valid), .payload(payload), .payload_valid(payload_valid),
        .payload_last(payload_last), .payload_chan(payload_chan), .frame_drop(frame_drop),
        .ok_count(ok_count), .drop_count(drop_count)
    );

    udp_rx_demux #(.ACCEPT_BCAST(1'b0)) u_dut_nb (
        .clk(clk), .resetn(resetn), .data_valid(data_valid), .received_byte(received_byte),
        .byte_valid(byte_valid), .payload(payload_nb), .payload_valid(payload_valid_nb),
        .payload_last(payload_last_nb), .payload_chan(payload_chan_nb), .frame_drop(frame_drop_nb),
        .ok_count(ok_count_nb), .drop_count(drop_count_nb)
    );

    udp_rx_demux #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .resetn(resetn), .data_valid(data_valid), .received_byte(received_byte),
        .byte_valid(byte_valid), .payload(payload_sat), .payload_valid(payload_valid_sat),
        .payload_last(payload_last_sat), .payload_chan(payload_chan_sat), .frame_drop(frame_drop_sat),
        .ok_count(ok_count_sat), .drop_count(drop_count_sat)
    );

    // Output monitor: samples on the falling edge, away from the active edge.
    typedef struct { logic [7:0] d; logic l; logic [1:0] c; } cap_t;
    cap_t cap[$];
    int   fd_cnt = 0;
    int   fd_long = 0;
    logic fd_prev = 1'b0;

    always @(negedge clk) begin
        if (payload_valid) cap.push_back('{payload, payload_last, payload_chan});
        if (frame_drop) begin
            fd_cnt++;
            if (fd_prev) fd_long++;
        end
        fd_prev = frame_drop;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int tot_ok = 0;
    int tot_drop = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bq_t build(input logic [47:0] mac, input logic [15:0] etype, input logic [7:0] verihl,
                                  input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                                  input logic [15:0] ulen, input bq_t pl);
        bq_t f;
        logic [15:0] tlen;
        f = {};
        tlen = ulen + 16'd20;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) f.push_back(mac[8*(5-i) +: 8]);
        f.push_back(8'h02); for (int i = 0; i < 4; i++) f.push_back(8'h00); f.push_back(8'h01);
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        f.push_back(verihl); f.push_back(8'h00); f.push_back(tlen[15:8]); f.push_back(tlen[7:0]);
        f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'h40); f.push_back(proto); f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'hC0); f.push_back(8'h00); f.push_back(8'h02); f.push_back(8'h01);
        for (int i = 0; i < 4; i++) f.push_back(dip[8*(3-i) +: 8]);
        f.push_back(8'h04); f.push_back(8'hD2);
        f.push_back(dport[15:8]); f.push_back(dport[7:0]);
        f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        foreach (pl[i]) f.push_back(pl[i]);
        while (f.size() - 8 < 60) f.push_back(8'h00);
        for (int i = 0; i < 4; i++) f.push_back(8'(i * 37 + 11));
        return f;
    endfunction

    // Frame-level reference: decide the fate of the first n bytes of f as a whole.
    function automatic void model(input bq_t f, input int n, input bit bc_ok, output bq_t pl,
                                  output int ok, output int drop, output int fd, output int chan);
        int i, h, plen, avail, port, ulen;
        bit good;
        logic [47:0] m;
        pl = {}; ok = 0; drop = 0; fd = 0; chan = 0;
        i = 0;
        while (i < n && f[i] == 8'h55) i++;
        if (i >= n || f[i] != 8'hD5) return;
        h = i + 1;
        if (n < h + 42) begin drop = 1; return; end
        m = {f[h], f[h+1], f[h+2], f[h+3], f[h+4], f[h+5]};
        good = (m == MAC) || (bc_ok && m == 48'hFFFF_FFFF_FFFF);
        good = good && ({f[h+12], f[h+13]} == 16'h0800);
        good = good && (f[h+14] == 8'h45) && (f[h+23] == 8'd17);
        good = good && ({f[h+30], f[h+31], f[h+32], f[h+33]} == IP);
        port = int'({f[h+36], f[h+37]});
        ulen = int'({f[h+38], f[h+39]});
        good = good && (port >= BASE) && (port < BASE + NUM) && (ulen >= 8);
        if (!good) begin drop = 1; return; end
        chan = port - BASE;
        plen = ulen - 8;
        avail = n - (h + 42);
        for (int k = 0; k < plen && k < avail; k++) pl.push_back(f[h+42+k]);
        if (avail >= plen) ok = 1;
        else begin drop = 1; fd = 1; end
    endfunction

    task automatic send_bytes(input bq_t f, input int from, input int to, input int spacing, input bit end_last);
        for (int i = from; i < to; i++) begin
            received_byte = f[i];
            byte_valid = 1'b1;
            if (end_last && i == to - 1) data_valid = 1'b0;
            @(negedge clk);
            byte_valid = 1'b0;
            repeat (spacing - 1) @(negedge clk);
        end
    endtask

    task automatic send(input bq_t f, input int n, input bit same_end, input int spacing, input int gap);
        data_valid = 1'b1;
        repeat (2) @(negedge clk);
        send_bytes(f, 0, n, spacing, same_end);
        data_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input bq_t f, input int n, input bit same_end,
                             input int spacing, input int gap, input bq_t epl, input int eok,
                             input int edrop, input int efd, input int echan, input int eok_nb,
                             input int edrop_nb);
        int c0, fd0, ns, nbad_d, nbad_c, lpos, nlast, elpos;
        logic [15:0] ok0, dr0, okn0, drn0;
        c0 = cap.size(); fd0 = fd_cnt;
        ok0 = ok_count; dr0 = drop_count; okn0 = ok_count_nb; drn0 = drop_count_nb;
        send(f, n, same_end, spacing, gap);
        repeat (3) @(negedge clk);
        #1;
        ns = cap.size() - c0;
        chk($sformatf("%s_strobes", name), ns, epl.size());
        nbad_d = 0; nbad_c = 0; lpos = -1; nlast = 0;
        for (int k = 0; k < ns; k++) begin
            if (k < epl.size() && cap[c0+k].d !== epl[k]) nbad_d++;
            if (cap[c0+k].c !== 2'(echan)) nbad_c++;
            if (cap[c0+k].l) begin nlast++; lpos = k; end
        end
        if (nlast > 1) lpos = -2;
        elpos = (eok != 0 && epl.size() > 0) ? epl.size() - 1 : -1;
        if (ns > 0) begin
            chk($sformatf("%s_data", name), nbad_d, 0);
            chk($sformatf("%s_chan_strobe", name), nbad_c, 0);
        end
        chk($sformatf("%s_last_pos", name), lpos, elpos);
        if (eok != 0) chk($sformatf("%s_chan", name), payload_chan, echan);
        chk($sformatf("%s_frame_drop", name), fd_cnt - fd0, efd);
        chk($sformatf("%s_ok", name), 16'(ok_count - ok0), eok);
        chk($sformatf("%s_drop", name), 16'(drop_count - dr0), edrop);
        chk($sformatf("%s_ok_nb", name), 16'(ok_count_nb - okn0), eok_nb);
        chk($sformatf("%s_drop_nb", name), 16'(drop_count_nb - drn0), edrop_nb);
        tot_ok += eok;
        tot_drop += edrop;
    endtask

    typedef struct {
        string       name;
        logic [47:0] mac;
        logic [15:0] port;
        logic [7:0]  proto;
        logic [15:0] ulen;
        int          npl;
        logic [31:0] pdat;
        int          cut;
        bit          same_end;
        int          e_str;
        int          e_ok;
        int          e_drop;
        int          e_fd;
        int          e_chan;
        int          e_ok_nb;
        int          e_drop_nb;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f, pl, epl, epl_nb, all;
        int n, eok, edrop, efd, echan, eok_nb, edrop_nb, efd_nb, echan_nb, c0, nb;
        logic [15:0] ok0, dr0;
        logic [63:0] rnd;
        logic [47:0] rmac;
        logic [15:0] et, rport, rulen;
        logic [7:0] vi, pr;
        logic [31:0] dip;
        int plen;

        //            name               mac             port  pr  ulen npl pdat          cut sme str ok dr fd ch okn drn
        vecs[0]  = '{"valid_5006",       MAC,            5006, 17, 12, 4, 32'hDEADBEEF, -1, 0, 4, 1, 0, 0, 1, 1, 0};
        vecs[1]  = '{"bad_mac",          48'h001122334455, 5006, 17, 12, 4, 32'hDEADBEEF, -1, 0, 0, 0, 1, 0, 1, 0, 1};
        vecs[2]  = '{"bcast",            48'hFFFFFFFFFFFF, 5005, 17, 12, 4, 32'h01020304, -1, 0, 4, 1, 0, 0, 0, 0, 1};
        vecs[3]  = '{"port_5009",        MAC,            5009, 17, 12, 4, 32'h01020304, -1, 0, 0, 0, 1, 0, 0, 0, 1};
        vecs[4]  = '{"proto_6",          MAC,            5006,  6, 12, 4, 32'h01020304, -1, 0, 0, 0, 1, 0, 1, 0, 1};
        vecs[5]  = '{"min_frame",        MAC,            5008, 17,  9, 1, 32'h42000000, -1, 0, 1, 1, 0, 0, 3, 1, 0};
        vecs[6]  = '{"trunc_2of4",       MAC,            5006, 17, 12, 4, 32'hDEADBEEF, 44, 0, 2, 0, 1, 1, 1, 0, 1};
        vecs[7]  = '{"zero_len",         MAC,            5007, 17,  8, 0, 32'h00000000, -1, 0, 0, 1, 0, 0, 2, 1, 0};
        vecs[8]  = '{"len_7",            MAC,            5006, 17,  7, 0, 32'h00000000, -1, 0, 0, 0, 1, 0, 1, 0, 1};
        vecs[9]  = '{"same_cycle_last",  MAC,            5006, 17, 12, 4, 32'hCAFEF00D, 46, 1, 4, 1, 0, 0, 1, 1, 0};
        vecs[10] = '{"hdr_trunc",        MAC,            5006, 17, 12, 4, 32'h01020304, 20, 0, 0, 0, 1, 0, 1, 0, 1};
        vecs[11] = '{"port_5004",        MAC,            5004, 17, 12, 4, 32'h01020304, -1, 0, 0, 0, 1, 0, 0, 0, 1};
        vecs[12] = '{"same_cycle_trunc", MAC,            5005, 17, 12, 4, 32'h11223344, 45, 1, 3, 0, 1, 1, 0, 0, 1};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_payload_valid", payload_valid, 0);
        chk("rst_payload_last", payload_last, 0);
        chk("rst_frame_drop", frame_drop, 0);
        chk("rst_payload", payload, 0);
        chk("rst_chan", payload_chan, 0);
        chk("rst_ok", ok_count, 0);
        chk("rst_drop", drop_count, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table.
        for (int v = 0; v < 13; v++) begin
            pl = {};
            for (int k = 0; k < vecs[v].npl; k++)
                pl.push_back((k < 4) ? vecs[v].pdat[31-8*k -: 8] : 8'(8'h60 + k));
            f = build(vecs[v].mac, 16'h0800, 8'h45, vecs[v].proto, IP, vecs[v].port, vecs[v].ulen, pl);
            n = (vecs[v].cut < 0) ? f.size() : 8 + vecs[v].cut;
            epl = {};
            for (int k = 0; k < vecs[v].e_str; k++) epl.push_back(pl[k]);
            run_frame(vecs[v].name, f, n, vecs[v].same_end, 4, 3, epl, vecs[v].e_ok, vecs[v].e_drop,
                      vecs[v].e_fd, vecs[v].e_chan, vecs[v].e_ok_nb, vecs[v].e_drop_nb);
        end

        // Reset in the middle of a payload.
        pl = {};
        for (int k = 0; k < 8; k++) pl.push_back(8'(8'hA0 + k));
        f = build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd5006, 16'd16, pl);
        data_valid = 1'b1;
        repeat (2) @(negedge clk);
        send_bytes(f, 0, 8 + 42 + 3, 4, 1'b0);
        received_byte = f[8 + 42 + 3];
        byte_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("midrst_valid_before", payload_valid, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", payload_valid, 0);
        chk("midrst_payload", payload, 0);
        chk("midrst_chan", payload_chan, 0);
        chk("midrst_ok", ok_count, 0);
        chk("midrst_drop", drop_count, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ok", ok_count, 0);
        chk("post_rst_drop", drop_count, 0);
        tot_ok = 0;
        tot_drop = 0;

        // Back-to-back frames with 1 and 12 idle cycles between them.
        c0 = cap.size(); ok0 = ok_count; dr0 = drop_count;
        all = {};
        for (int j = 0; j < 3; j++) begin
            pl = {};
            for (int k = 0; k < 3; k++) pl.push_back(8'(16 * j + k + 1));
            foreach (pl[k]) all.push_back(pl[k]);
            f = build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'(BASE + j), 16'd11, pl);
            send(f, f.size(), 1'b0, 4, (j == 1) ? 12 : 1);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("b2b_strobes", cap.size() - c0, all.size());
        nb = 0;
        for (int k = 0; k < all.size() && c0 + k < cap.size(); k++)
            if (cap[c0+k].d !== all[k]) nb++;
        chk("b2b_data", nb, 0);
        chk("b2b_ok", 16'(ok_count - ok0), 3);
        chk("b2b_drop", 16'(drop_count - dr0), 0);
        tot_ok += 3;

        // Randomised frames against the frame-level reference.
        for (int r = 0; r < 40; r++) begin
            rnd = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                7: rmac = 48'hFFFF_FFFF_FFFF;
                8, 9: rmac = rnd[47:0];
                default: rmac = MAC;
            endcase
            et = ($urandom_range(0, 19) == 0) ? 16'h86DD : 16'h0800;
            vi = ($urandom_range(0, 19) == 0) ? 8'h46 : 8'h45;
            pr = ($urandom_range(0, 9) == 0) ? 8'd6 : 8'd17;
            dip = ($urandom_range(0, 14) == 0) ? (IP ^ 32'd1) : IP;
            rport = 16'(BASE - 1 + int'($urandom_range(0, NUM + 1)));
            plen = int'($urandom_range(0, 24));
            rulen = ($urandom_range(0, 14) == 0) ? 16'($urandom_range(0, 7)) : 16'(plen + 8);
            pl = {};
            for (int k = 0; k < plen; k++) pl.push_back(8'($urandom_range(0, 255)));
            f = build(rmac, et, vi, pr, dip, rport, rulen, pl);
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, f.size())) : f.size();
            model(f, n, 1'b1, epl, eok, edrop, efd, echan);
            model(f, n, 1'b0, epl_nb, eok_nb, edrop_nb, efd_nb, echan_nb);
            run_frame($sformatf("rnd%0d", r), f, n, 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
                      epl, eok, edrop, efd, echan, eok_nb, edrop_nb);
        end

        chk("frame_drop_width", fd_long, 0);
        chk("sat_ok", ok_count_sat, (tot_ok > 3) ? 3 : tot_ok);
        chk("sat_drop", drop_count_sat, (tot_drop > 3) ? 3 : tot_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
